// File: rtl/cdc_pkg.sv
// Shared CDC types: reset-sequencer FSM states and counter sizing helper.
// Latency: n/a (types only).  Backpressure: n/a.
package cdc_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_HOLD,
        S_RELEASE,
        S_DONE,
        S_REASSERT
    } rst_seq_state_t;

    // Wide enough to hold the larger terminal count without wrapping.
    function automatic int rst_seq_cnt_w(input int hold_cycles, input int stagger_cycles);
        return $clog2(((hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles) + 1);
    endfunction

endpackage

// File: rtl/cdc_reset_sequencer_if.sv
// Software-request / sequenced-reset bundle of the reset sequencer.
// Latency: n/a (wiring).  Backpressure: none, all signals are levels.
interface cdc_reset_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              sw_rst_req;
    logic [NUM_CH-1:0] rst_out;
    logic              seq_done;

    // master: the sequencer driving the resets; slave: the requester/consumer side.
    modport master (input sw_rst_req, output rst_out, output seq_done);
    modport slave  (output sw_rst_req, input rst_out, input seq_done);
endinterface

// File: rtl/cdc_rst_sync_chain.sv
// Async-assert / sync-deassert reset synchroniser, SYNC_DEPTH flops deep.
// Latency: rst_sync falls after SYNC_DEPTH dst_clk edges; rises immediately.  Backpressure: none.
module cdc_rst_sync_chain #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic dst_clk,
    input  logic rst_async,
    output logic rst_sync
);

    logic [SYNC_DEPTH-1:0] chain_q;

    always_ff @(posedge dst_clk or posedge rst_async) begin
        if (rst_async) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[SYNC_DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync = chain_q[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_reset_sequencer.sv
// Ordered reset-tree root: async assert of all channels, staggered ascending release; optional CDC_RST_SEQ_REVERSE_ASSERT_EN.
// Latency: rst_out[i] falls SYNC_DEPTH+HOLD_CYCLES+i*STAGGER_CYCLES edges after rst_async drops.
// Backpressure: none; sw_rst_req is sampled every edge and ignored only while the async reset propagates.
module cdc_reset_sequencer
    import cdc_pkg::*;
#(
    parameter int SYNC_DEPTH     = 2,
    parameter int NUM_CH         = 4,
    parameter int HOLD_CYCLES    = 4,
    parameter int STAGGER_CYCLES = 2
) (
    input  logic                  dst_clk,
    input  logic                  rst_async,
    cdc_reset_sequencer_if.master seq_if
);

    localparam int CW = rst_seq_cnt_w(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

`ifdef CDC_RST_SEQ_REVERSE_ASSERT_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    logic              rst_sync;
    rst_seq_state_t    state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [NUM_CH-1:0] rst_q;
    logic              done_q;
    logic              sw_restart;

    cdc_rst_sync_chain #(
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_sync (
        .dst_clk   (dst_clk),
        .rst_async (rst_async),
        .rst_sync  (rst_sync)
    );

    assign idx_nxt = idx + 1'b1;

`ifdef CDC_RST_SEQ_REVERSE_ASSERT_EN
    logic [IW-1:0] idx_prv;
    assign idx_prv = idx - 1'b1;
`endif

    always_comb begin
        sw_restart = seq_if.sw_rst_req &&
                     ((state == S_HOLD) || (state == S_RELEASE) || ((state == S_DONE) && !REV_EN));
    end

    always_ff @(posedge dst_clk or posedge rst_async) begin
        if (rst_async) begin
            state  <= S_SYNC;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
        end else if (sw_restart) begin
            state  <= S_HOLD;
            cnt    <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
        end else begin
            case (state)
                // The edge that first sees rst_sync low is already hold cycle one,
                // which keeps channel 0 release at SYNC_DEPTH+HOLD_CYCLES.
                S_SYNC, S_HOLD: begin
                    if ((state == S_HOLD) || !rst_sync) begin
                        if (cnt == HOLD_LAST) begin
                            rst_q[0] <= 1'b0;
                            idx      <= '0;
                            cnt      <= '0;
                            if (NUM_CH == 1) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state  <= S_RELEASE;
                            end
                        end else begin
                            state <= S_HOLD;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (cnt == STAG_LAST) begin
                        rst_q[idx_nxt] <= 1'b0;
                        idx            <= idx_nxt;
                        cnt            <= '0;
                        if (idx_nxt == IDX_LAST) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
`ifdef CDC_RST_SEQ_REVERSE_ASSERT_EN
                    if (seq_if.sw_rst_req) begin
                        rst_q[NUM_CH-1] <= 1'b1;
                        done_q          <= 1'b0;
                        cnt             <= '0;
                        idx             <= IDX_LAST;
                        state           <= (NUM_CH == 1) ? S_HOLD : S_REASSERT;
                    end
`endif
                end
`ifdef CDC_RST_SEQ_REVERSE_ASSERT_EN
                S_REASSERT: begin
                    if (cnt == STAG_LAST) begin
                        rst_q[idx_prv] <= 1'b1;
                        idx            <= idx_prv;
                        cnt            <= '0;
                        if (idx_prv == '0) begin
                            state <= S_HOLD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state  <= S_SYNC;
                    cnt    <= '0;
                    rst_q  <= '1;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.rst_out  = rst_q;
    assign seq_if.seq_done = done_q;

endmodule

// File: doc/cdc_reset_sequencer.md
Name: cdc_reset_sequencer

Overview:
Parametrised successor to the basic reset synchroniser. It takes one asynchronous active-high reset into the dst_clk domain and asserts NUM_CH reset outputs immediately. On deassertion it releases those outputs one at a time, in ascending order and at a programmable spacing, after a minimum hold time. A synchronous software request re-runs the whole sequence. It sits at the root of each clock domain's reset tree, so IP blocks come out of reset in order: interconnect first, masters last.

Parameters:
SYNC_DEPTH, 2, synchroniser flop count on the rst_async deassert path; legal values >= 2.
NUM_CH, 4, number of sequenced reset outputs; legal values >= 1.
HOLD_CYCLES, 4, dst_clk cycles all outputs stay asserted after the synchronised deassert (or after sw reassertion) before channel 0 releases; legal values >= 1.
STAGGER_CYCLES, 2, dst_clk cycles between consecutive channel releases; legal values >= 1.

Ports:
dst_clk  input  1  destination-domain clock.
rst_async  input  1  asynchronous reset, active-high. It is the only reset of the block.
sw_rst_req  input  1  synchronous software reset request, sampled every dst_clk edge, level or pulse.
rst_out  output  NUM_CH  sequenced resets, active-high. Bit i feeds channel i.
seq_done  output  1  high once every rst_out bit has released; low otherwise.

Behaviour:
- Reset is asynchronous and active-high. While rst_async=1: rst_out = all-ones, seq_done = 0, synchroniser chain = all-ones, FSM = S_SYNC, counters = 0. All of these take effect immediately, with no clock required.
- Edge numbering: edge 1 is the first dst_clk rising edge with rst_async=0. The internal rst_sync signal falls after edge SYNC_DEPTH.
- FSM states: S_SYNC, S_HOLD, S_RELEASE, S_DONE, S_REASSERT (S_REASSERT is used only with the optional feature).
- S_SYNC: stay while rst_sync=1. On the first edge that sees rst_sync=0, move to S_HOLD with the counter cleared.
- S_HOLD: count HOLD_CYCLES edges, then move to S_RELEASE with idx=0.
- Release timing from async reset: rst_out[i] falls after edge SYNC_DEPTH + HOLD_CYCLES + i*STAGGER_CYCLES.
- S_RELEASE: clear rst_out[idx]. If idx == NUM_CH-1, go to S_DONE and set seq_done on the same edge. Otherwise wait STAGGER_CYCLES, then increment idx.
- Released channels stay released. rst_out bits are registered and free of combinational glitches.
- sw_rst_req=1 at edge n, in any state other than S_SYNC or S_REASSERT:
  - rst_out = all-ones and seq_done = 0 after edge n.
  - FSM goes to S_HOLD with the counter cleared.
  - rst_out[0] falls after edge n + HOLD_CYCLES.
  - The rest follows the normal stagger.
- sw_rst_req in S_SYNC: ignored, because async reset is still propagating.
- If sw_rst_req is held high, the FSM stays in S_HOLD with the counter cleared and outputs asserted until the request drops.
- rst_async asserting mid-sequence (any state) overrides everything and restarts from the async reset state.
- NUM_CH=1: seq_done rises on the same edge rst_out[0] falls.
- Counter width is $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). The idx width is $clog2(NUM_CH) with a minimum of 1. Terminal counts must not wrap.

Optional Feature:
Macro: CDC_RST_SEQ_REVERSE_ASSERT_EN.
- Defined: a sw_rst_req seen in S_DONE at edge n goes to S_REASSERT instead of S_HOLD.
  - S_REASSERT asserts channels in descending order. rst_out[NUM_CH-1-k] rises after edge n + k*STAGGER_CYCLES.
  - After the last channel asserts at edge m, the FSM enters S_HOLD. rst_out[0] falls after edge m + HOLD_CYCLES.
  - sw_rst_req during S_REASSERT is ignored.
  - sw_rst_req seen in S_HOLD or S_RELEASE still asserts all channels at once.
- Undefined: S_REASSERT is not built, and every sw_rst_req asserts all channels together.
- Async assertion is always simultaneous on all channels, with or without the macro.

Decomposition:
- cdc_pkg (shared CDC package) holds:
  - the rst_seq_state_t enum (S_SYNC, S_HOLD, S_RELEASE, S_DONE, S_REASSERT);
  - a localparam helper for the counter width.
- One sub-module, cdc_rst_sync_chain: an active-high async-assert / sync-deassert flop chain, SYNC_DEPTH deep, producing rst_sync. The sequencer instantiates one.

Test Plan (defaults SYNC_DEPTH=2, NUM_CH=4, HOLD_CYCLES=4, STAGGER_CYCLES=2):
- Release rst_async before edge 1 -> rst_out[0..3] fall after edges 6, 8, 10, 12; seq_done=1 after edge 12; rst_out=4'hF before edge 6.
- Assert rst_async mid-clock-period while in S_DONE -> rst_out=4'hF and seq_done=0 immediately, before the next dst_clk edge.
- One-cycle sw_rst_req at edge 20 while in S_DONE (macro off) -> rst_out=4'hF after edge 20; bits fall after edges 24, 26, 28, 30; seq_done after 30.
- sw_rst_req at edge 9 during S_RELEASE -> rst_out=4'hF after edge 9; restart gives falls after edges 13, 15, 17, 19.
- sw_rst_req held high for edges 20-25 -> outputs asserted throughout; rst_out[0] falls after edge 25+4=29.
- Macro on, sw_rst_req at edge 20 in S_DONE -> rst_out[3], [2], [1], [0] rise after edges 20, 22, 24, 26; releases after edges 30, 32, 34, 36.
